// File: rtl/game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// game_flow_ctrl
//   Top-level game sequencer. Owns the game-mode FSM (title, countdown, play,
//   pause, dying, game over), gates the physics/scroll datapath with run_en,
//   pulses game_reset to clear player/score/platforms, and shrinks the
//   platform width as the score climbs.
//
// Ports
//   Clk            in   system clock
//   Reset          in   asynchronous active-low reset
//   frame_clk      in   raw frame strobe from the VGA controller (async level)
//   keycode        in   [7:0]  current USB keycode, 0 = none
//   health         in   [9:0]  player health
//   score          in   [15:0] current score
//   state          out  [7:0]  0 TITLE, 1 PLAY, 2 GAMEOVER, 3 COUNTDOWN,
//                              4 PAUSE, 5 DYING
//   run_en         out  high only in PLAY
//   frame_tick     out  one-Clk pulse per frame_clk rising edge
//   game_reset     out  one-Clk pulse on entry to COUNTDOWN from TITLE/GAMEOVER
//   countdown_sec  out  [1:0]  seconds left in COUNTDOWN (3..1), else 0
//   platform_size  out  [7:0]  current platform width
//   best_score     out  [15:0] best score since reset
// -----------------------------------------------------------------------------
module game_flow_ctrl #(
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int DYING_FRAMES     = 60,
  parameter int PLAT_MAX         = 30,
  parameter int PLAT_MIN         = 12,
  parameter int SCORE_STEP       = 500
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  input  logic [9:0]  health,
  input  logic [15:0] score,
  output logic [7:0]  state,
  output logic        run_en,
  output logic        frame_tick,
  output logic        game_reset,
  output logic [1:0]  countdown_sec,
  output logic [7:0]  platform_size,
  output logic [15:0] best_score
);

  localparam logic [7:0] ST_TITLE     = 8'd0;
  localparam logic [7:0] ST_PLAY      = 8'd1;
  localparam logic [7:0] ST_GAMEOVER  = 8'd2;
  localparam logic [7:0] ST_COUNTDOWN = 8'd3;
  localparam logic [7:0] ST_PAUSE     = 8'd4;
  localparam logic [7:0] ST_DYING     = 8'd5;

  localparam logic [7:0] KEY_ENTER = 8'd40;
  localparam logic [7:0] KEY_ESC   = 8'd41;
  localparam logic [7:0] KEY_P     = 8'd19;

  localparam int CNT_MAX = (COUNTDOWN_FRAMES > DYING_FRAMES) ? COUNTDOWN_FRAMES : DYING_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic             fc_p0, fc_p1, fc_p2;
  logic [7:0]       key_prev;
  logic [CNT_W-1:0] frame_cnt;
  logic [16:0]      threshold;
  logic             press_enter, press_esc, press_p;
  logic [CNT_W+1:0] cnt_x3;

  // One difficulty step: narrow by 2, never below the floor.
  function automatic logic [7:0] shrink_size(input logic [7:0] size);
    if (size >= 8'(PLAT_MIN + 2)) return size - 8'd2;
    else                          return 8'(PLAT_MIN);
  endfunction

  // ---- stage: frame_clk synchroniser, edge detect and key history ----
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fc_p0      <= 1'b0;
      fc_p1      <= 1'b0;
      fc_p2      <= 1'b0;
      frame_tick <= 1'b0;
      key_prev   <= 8'd0;
    end else begin
      fc_p0      <= frame_clk;
      fc_p1      <= fc_p0;
      fc_p2      <= fc_p1;
      frame_tick <= fc_p1 & ~fc_p2;
      key_prev   <= keycode;
    end
  end

  assign press_enter = (keycode == KEY_ENTER) && (key_prev != KEY_ENTER);
  assign press_esc   = (keycode == KEY_ESC)   && (key_prev != KEY_ESC);
  assign press_p     = (keycode == KEY_P)     && (key_prev != KEY_P);

  // ---- stage: mode FSM, frame counter, difficulty and best score ----
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state         <= ST_TITLE;
      game_reset    <= 1'b0;
      frame_cnt     <= '0;
      threshold     <= 17'(SCORE_STEP);
      platform_size <= 8'(PLAT_MAX);
      best_score    <= 16'd0;
    end else begin
      game_reset <= 1'b0;

      // At most one difficulty step per frame, only while actually playing.
      if (state == ST_PLAY && frame_tick && ({1'b0, score} >= threshold)) begin
        threshold     <= threshold + 17'(SCORE_STEP);
        platform_size <= shrink_size(platform_size);
      end

      case (state)
        ST_TITLE: begin
          if (press_enter) begin
            state         <= ST_COUNTDOWN;
            frame_cnt     <= CNT_W'(COUNTDOWN_FRAMES);
            game_reset    <= 1'b1;
            platform_size <= 8'(PLAT_MAX);
            threshold     <= 17'(SCORE_STEP);
          end
        end
        ST_COUNTDOWN: begin
          // Esc beats an expiry landing on the same cycle.
          if (press_esc) begin
            state <= ST_TITLE;
          end else if (frame_tick) begin
            if (frame_cnt == CNT_W'(1)) state <= ST_PLAY;
            else                        frame_cnt <= frame_cnt - CNT_W'(1);
          end
        end
        ST_PLAY: begin
          if (health == 10'd0) begin
            state     <= ST_DYING;
            frame_cnt <= CNT_W'(DYING_FRAMES);
            if (score > best_score) best_score <= score;
          end else if (press_esc) begin
            state <= ST_TITLE;
          end else if (press_p) begin
            state <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (press_esc)                 state <= ST_TITLE;
          else if (press_p || press_enter) state <= ST_PLAY;
        end
        ST_DYING: begin
          if (frame_tick) begin
            if (frame_cnt == CNT_W'(1)) state <= ST_GAMEOVER;
            else                        frame_cnt <= frame_cnt - CNT_W'(1);
          end
        end
        ST_GAMEOVER: begin
          if (press_esc) begin
            state <= ST_TITLE;
          end else if (press_enter) begin
            state         <= ST_COUNTDOWN;
            frame_cnt     <= CNT_W'(COUNTDOWN_FRAMES);
            game_reset    <= 1'b1;
            platform_size <= 8'(PLAT_MAX);
            threshold     <= 17'(SCORE_STEP);
          end
        end
        default: state <= ST_TITLE;
      endcase
    end
  end

  // ceil(cnt*3/N) without a divider: compare 3*cnt against N and 2N.
  assign cnt_x3 = {2'b00, frame_cnt} + {1'b0, frame_cnt, 1'b0};

  always_comb begin
    countdown_sec = 2'd0;
    if (state == ST_COUNTDOWN) begin
      if (cnt_x3 > (CNT_W+2)'(2 * COUNTDOWN_FRAMES)) countdown_sec = 2'd3;
      else if (cnt_x3 > (CNT_W+2)'(COUNTDOWN_FRAMES)) countdown_sec = 2'd2;
      else if (frame_cnt != '0)                      countdown_sec = 2'd1;
    end
  end

  assign run_en = (state == ST_PLAY);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_flow_ctrl
//   Directed and randomized checks of game_flow_ctrl against a mode-level
//   reference model (modes, frames remaining, difficulty steps taken).
// -----------------------------------------------------------------------------
module tb_game_flow_ctrl;

  localparam int T_PLAY = 1, T_OVER = 2, T_CD = 3, T_PAUSE = 4, T_DYING = 5, T_TITLE = 0;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_clk = 1'b0;
  logic [7:0]  keycode = 8'd0;
  logic [9:0]  health = 10'd100;
  logic [15:0] score = 16'd0;
  logic [7:0]  state;
  logic        run_en, frame_tick, game_reset;
  logic [1:0]  countdown_sec;
  logic [7:0]  platform_size;
  logic [15:0] best_score;

  always #5 Clk = ~Clk;

  game_flow_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .health(health), .score(score), .state(state), .run_en(run_en),
    .frame_tick(frame_tick), .game_reset(game_reset),
    .countdown_sec(countdown_sec), .platform_size(platform_size),
    .best_score(best_score)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model
  int m_state, m_cnt, m_steps, m_best, m_prevkey;
  bit m_tick, m_grst;
  bit h1, h2, h3;           // frame_clk as sampled 1, 2, 3 edges ago
  bit seen_sec [4];

  // Tick monitor for the free-running frame_clk section
  int mon_ticks = 0;
  int mon_dbl = 0;
  bit mon_prev = 1'b0;
  always @(negedge Clk) begin
    mon_prev <= frame_tick;
    if (frame_tick) begin
      mon_ticks <= mon_ticks + 1;
      if (mon_prev) mon_dbl <= mon_dbl + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_size();
    int s;
    s = 30 - 2 * m_steps;
    return (s < 12) ? 12 : s;
  endfunction

  function automatic int exp_sec();
    if (m_state == T_CD) return (m_cnt * 3 + 179) / 180;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = T_TITLE; m_cnt = 0; m_steps = 0; m_best = 0; m_prevkey = 0;
    m_tick = 0; m_grst = 0; h1 = 0; h2 = 0; h3 = 0;
  endtask

  // Applies the game rules for one Clk edge using the inputs present at it.
  task automatic model_edge();
    bit pe, px, pp, tk;
    int kc;
    kc = int'(keycode);
    pe = (kc == 40) && (m_prevkey != 40);
    px = (kc == 41) && (m_prevkey != 41);
    pp = (kc == 19) && (m_prevkey != 19);
    tk = m_tick;
    m_grst = 0;
    case (m_state)
      T_TITLE: if (pe) begin m_state = T_CD; m_cnt = 180; m_grst = 1; m_steps = 0; end
      T_CD: begin
        if (px) m_state = T_TITLE;
        else if (tk) begin
          if (m_cnt == 1) m_state = T_PLAY; else m_cnt--;
        end
      end
      T_PLAY: begin
        if (tk && int'(score) >= 500 * (m_steps + 1)) m_steps++;
        if (health == 10'd0) begin
          m_state = T_DYING; m_cnt = 60;
          if (int'(score) > m_best) m_best = int'(score);
        end else if (px) m_state = T_TITLE;
        else if (pp) m_state = T_PAUSE;
      end
      T_PAUSE: begin
        if (px) m_state = T_TITLE;
        else if (pp || pe) m_state = T_PLAY;
      end
      T_DYING: if (tk) begin
        if (m_cnt == 1) m_state = T_OVER; else m_cnt--;
      end
      T_OVER: begin
        if (px) m_state = T_TITLE;
        else if (pe) begin m_state = T_CD; m_cnt = 180; m_grst = 1; m_steps = 0; end
      end
      default: m_state = T_TITLE;
    endcase
    // A rise in the sampled stream shows up as a tick three edges later.
    m_tick = h2 & ~h3;
    h3 = h2; h2 = h1; h1 = frame_clk;
    m_prevkey = kc;
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_state));
    chk("run_en", 32'(run_en), 32'(m_state == T_PLAY));
    chk("frame_tick", 32'(frame_tick), 32'(m_tick));
    chk("game_reset", 32'(game_reset), 32'(m_grst));
    chk("countdown_sec", 32'(countdown_sec), 32'(exp_sec()));
    chk("platform_size", 32'(platform_size), 32'(exp_size()));
    chk("best_score", 32'(best_score), 32'(m_best));
    if (countdown_sec !== 2'bxx) seen_sec[countdown_sec] = 1'b1;
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic frame(input int n);
    repeat (n) begin
      frame_clk = 1'b1; step(); step();
      frame_clk = 1'b0; step(); step();
    end
  endtask

  // Asserts Reset mid-cycle, checks the asynchronous effect, releases it.
  task automatic do_reset();
    @(posedge Clk);
    #3 Reset = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge Clk);
    #1;
    check_all();
    Reset = 1'b1;
  endtask

  function automatic logic [7:0] rand_key();
    case ($urandom_range(0, 7))
      0, 1: return 8'd0;
      2, 3: return 8'd40;
      4, 5: return 8'd19;
      6:    return 8'd41;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int pulses, t0, rises, sz;
    model_reset();
    #12;
    check_all();
    Reset = 1'b1;
    #1;
    do_reset();

    // Enter held for 10 cycles gives exactly one game_reset.
    pulses = 0;
    keycode = 8'd40;
    repeat (10) begin
      step();
      if (game_reset === 1'b1) pulses++;
    end
    chk("enter_hold_pulses", 32'(pulses), 32'd1);
    chk("enter_state", 32'(state), 32'd3);
    keycode = 8'd0;

    // Full countdown into PLAY.
    foreach (seen_sec[i]) seen_sec[i] = 1'b0;
    frame(180);
    chk("cd_seen3", 32'(seen_sec[3]), 32'd1);
    chk("cd_seen2", 32'(seen_sec[2]), 32'd1);
    chk("cd_seen1", 32'(seen_sec[1]), 32'd1);
    chk("cd_to_play", 32'(state), 32'd1);
    chk("cd_run_en", 32'(run_en), 32'd1);

    // Pause: score changes while paused leave the width alone.
    keycode = 8'd19; step(); keycode = 8'd0; step();
    chk("pause_state", 32'(state), 32'd4);
    chk("pause_run_en", 32'(run_en), 32'd0);
    score = 16'd2000;
    frame(5);
    chk("pause_size", 32'(platform_size), 32'd30);
    score = 16'd0;
    step();
    keycode = 8'd19; step(); keycode = 8'd0; step();
    chk("resume_state", 32'(state), 32'd1);

    // Score ramp 0 -> 5000: width walks 30 down to 12 and holds.
    for (int i = 1; i <= 24; i++) begin
      score = (i * 250 > 5000) ? 16'd5000 : 16'(i * 250);
      frame(1);
    end
    chk("ramp_floor", 32'(platform_size), 32'd12);

    // Health drops on the same cycle as an Esc edge: dying wins.
    health = 10'd0; keycode = 8'd41; step();
    chk("dying_state", 32'(state), 32'd5);
    health = 10'd100; keycode = 8'd0;
    frame(60);
    chk("gameover_state", 32'(state), 32'd2);
    chk("best_at_entry", 32'(best_score), 32'd5000);

    // Enter in GAMEOVER restarts with full-width platforms.
    keycode = 8'd40; step();
    chk("restart_size", 32'(platform_size), 32'd30);
    chk("restart_state", 32'(state), 32'd3);
    keycode = 8'd0; score = 16'd0; step();
    frame(180);
    score = 16'd1200;
    frame(3);
    chk("midplay_state", 32'(state), 32'd1);
    do_reset();

    // Esc edge on the same cycle as the final countdown tick.
    keycode = 8'd40; step(); keycode = 8'd0; step();
    frame(179);
    frame_clk = 1'b1; step(); step(); frame_clk = 1'b0; step();
    keycode = 8'd41; step();
    chk("esc_beats_expiry", 32'(state), 32'd0);
    keycode = 8'd0; step(); step();

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 49) == 0) keycode = rand_key();
      health = ($urandom_range(0, 299) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      if (m_grst) score = 16'd0;
      else if (int'(score) < 65000) score = score + 16'($urandom_range(0, 30));
      if ($urandom_range(0, 1) == 0) frame_clk = ~frame_clk;
      step();
    end

    // frame_clk free-running and unaligned to Clk while in TITLE.
    do_reset();
    keycode = 8'd0;
    t0 = mon_ticks;
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      #($urandom_range(25, 90)) frame_clk = 1'b1;
      rises++;
      #($urandom_range(23, 97)) frame_clk = 1'b0;
    end
    #7 frame_clk = 1'b1;
    rises++;
    sz = mon_ticks;
    #400;
    chk("held_high_no_tick", 32'(mon_ticks - sz), 32'd1);
    chk("async_tick_count", 32'(mon_ticks - t0), 32'(rises));
    chk("async_no_double", 32'(mon_dbl), 32'd0);
    chk("async_title", 32'(state), 32'd0);
    frame_clk = 1'b0;
    #100;
    do_reset();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
